// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with a start/busy/done handshake.
// Operands are captured on an accepted start, summed one bit per clock
// LSB first, and the full result is published in a single update when the
// last bit has been processed.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic             done_r;
  logic             done_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       ha0_s;
  logic [1:0]       ha1_s;
  logic             bit_sum_s;
  logic             carry_next_s;
  logic             last_bit_s;

  // Full adder for the current bit: two half-adder stages plus an OR for carry.
  assign ha0_s        = half_add(a_sh_r[0], b_sh_r[0]);
  assign ha1_s        = half_add(ha0_s[0], carry_r);
  assign bit_sum_s    = ha1_s[0];
  assign carry_next_s = ha0_s[1] | ha1_s[1];
  assign last_bit_s   = (cnt_r == CW'(WIDTH - 1));

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

  // Next-state and registered-output decode for the control FSM.
  always_comb begin
    state_next_s = state_r;
    busy_next_s  = busy_r;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          busy_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          busy_next_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_next_s = ST_DONE;
          busy_next_s  = 1'b0;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_RUN;
          busy_next_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
      end
      default: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // FSM state and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  // Operand capture, per-bit shifting and one-shot result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
          end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
          end
        end
        ST_RUN: begin
          a_sh_r  <= a_sh_r >> 1;
          b_sh_r  <= b_sh_r >> 1;
          acc_r   <= {bit_sum_s, acc_r[WIDTH-1:1]};
          carry_r <= carry_next_s;
          if (last_bit_s) begin
            // The final bit enters at the MSB as the whole word is published.
            sum_r  <= {bit_sum_s, acc_r[WIDTH-1:1]};
            cout_r <= carry_next_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
